// File: rtl/counter_ctrl_if.sv
// Front-panel bundle: raw buttons/switches in from the board, registered
// control lines out to the four-digit counter bank.
`timescale 1ns/1ps
interface counter_ctrl_if;
  logic       btn_run;
  logic       btn_step;
  logic       btn_clr;
  logic       btn_load;
  logic       sw_up;
  logic [3:0] sw_di;
  logic       ce;
  logic       clr;
  logic       up;
  logic       L;
  logic [3:0] di;
  logic       running;

  modport master (
    output btn_run, btn_step, btn_clr, btn_load, sw_up, sw_di,
    input  ce, clr, up, L, di, running
  );

  modport slave (
    input  btn_run, btn_step, btn_clr, btn_load, sw_up, sw_di,
    output ce, clr, up, L, di, running
  );
endinterface

// File: rtl/counter_ctrl.sv
// Front-panel sequencer: synchronises and debounces the panel inputs, then
// drives the counter bank's ce/clr/up/L/di lines from a small registered FSM.
`timescale 1ns/1ps
module counter_ctrl #(
  parameter int DIV = 25_000_000,
  parameter int DEB = 250_000
) (
  input  logic          clk,
  input  logic          rst_n,
  counter_ctrl_if.slave io_panel
);

  localparam int NB = 9;
  localparam int CW = (DEB > 1) ? $clog2(DEB) : 1;
  localparam int PW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB - 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
  // Bit 4 is sw_up, which idles high so the up/down digit counts up after reset.
  localparam logic [NB-1:0] RST_LVL = 9'b0_0001_0000;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_STEP, S_LOAD, S_CLEAR} state_t;

  logic [NB-1:0] w_raw;
  logic [NB-1:0] r_meta;
  logic [NB-1:0] r_sync;
  logic [NB-1:0] r_level;
  logic [NB-1:0] r_deb;
  logic [CW-1:0] r_cnt [NB];
  logic [3:0]    r_debD;
  logic [3:0]    r_evt;
  logic          w_evtRun;
  logic          w_evtStep;
  logic          w_evtClr;
  logic          w_evtLoad;

  state_t        r_state;
  state_t        w_next;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_prescNext;
  logic          w_ceNext;
  logic          w_clrNext;
  logic          w_loadNext;
  logic          w_runningNext;
  logic [3:0]    w_diNext;

  logic          r_ce;
  logic          r_clr;
  logic          r_up;
  logic          r_load;
  logic [3:0]    r_di;
  logic          r_running;

  assign w_raw = {io_panel.btn_run, io_panel.btn_step, io_panel.btn_clr,
                  io_panel.btn_load, io_panel.sw_up, io_panel.sw_di};

  // r_level flips once the synchronised input has disagreed for DEB cycles;
  // r_deb is the registered copy everything downstream uses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta  <= RST_LVL;
      r_sync  <= RST_LVL;
      r_level <= RST_LVL;
      r_deb   <= RST_LVL;
      for (int i = 0; i < NB; i++) r_cnt[i] <= '0;
    end else begin
      r_meta <= w_raw;
      r_sync <= r_meta;
      r_deb  <= r_level;
      for (int i = 0; i < NB; i++) begin
        if (r_sync[i] == r_level[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_level[i] <= r_sync[i];
          r_cnt[i]   <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_debD <= '0;
      r_evt  <= '0;
    end else begin
      r_debD <= r_deb[8:5];
      r_evt  <= r_deb[8:5] & ~r_debD;
    end
  end

  assign w_evtRun  = r_evt[3];
  assign w_evtStep = r_evt[2];
  assign w_evtClr  = r_evt[1];
  assign w_evtLoad = r_evt[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_presc <= '0;
    end else begin
      r_state <= w_next;
      r_presc <= w_prescNext;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_evtClr)       w_next = S_CLEAR;
        else if (w_evtLoad) w_next = S_LOAD;
        else if (w_evtRun)  w_next = S_RUN;
        else if (w_evtStep) w_next = S_STEP;
      end
      S_RUN: begin
        if (w_evtClr)       w_next = S_CLEAR;
        else if (w_evtLoad) w_next = S_LOAD;
        else if (w_evtRun)  w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so the registered lines line
  // up with r_state; the prescaler ce is dropped on the edge that leaves RUN.
  always_comb begin
    w_ceNext      = (w_next == S_STEP) ||
                    (r_state == S_RUN && w_next == S_RUN && r_presc == PRE_MAX);
    w_clrNext     = (w_next == S_CLEAR);
    w_loadNext    = (w_next == S_LOAD);
    w_runningNext = (w_next == S_RUN);
    w_diNext      = (w_next == S_LOAD) ? r_deb[3:0] : r_di;
    w_prescNext   = '0;
    if (r_state == S_RUN && w_next == S_RUN) begin
      w_prescNext = (r_presc == PRE_MAX) ? '0 : r_presc + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ce      <= 1'b0;
      r_clr     <= 1'b0;
      r_up      <= 1'b1;
      r_load    <= 1'b0;
      r_di      <= '0;
      r_running <= 1'b0;
    end else begin
      r_ce      <= w_ceNext;
      r_clr     <= w_clrNext;
      r_up      <= r_deb[4];
      r_load    <= w_loadNext;
      r_di      <= w_diNext;
      r_running <= w_runningNext;
    end
  end

  assign io_panel.ce      = r_ce;
  assign io_panel.clr     = r_clr;
  assign io_panel.up      = r_up;
  assign io_panel.L       = r_load;
  assign io_panel.di      = r_di;
  assign io_panel.running = r_running;

endmodule
